// File: rtl/axi_nsaid_tagger.sv
// rtl/axi_nsaid_tagger.sv - AXI request tagger attaching a drain-synchronised NSAID to AW/AR
package axi_nsaid_tagger_pkg;
    localparam int IdW   = 4;
    localparam int AddrW = 32;
    localparam int DataW = 32;
    localparam int StrbW = DataW / 8;
    localparam int UserW = 1;

    typedef logic [3:0] nsaid_t;

    typedef struct packed {
        logic [IdW-1:0]   id;
        logic [AddrW-1:0] addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        logic             lock;
        logic [3:0]       cache;
        logic [2:0]       prot;
        logic [3:0]       qos;
        logic [UserW-1:0] user;
    } ax_chan_t;

    typedef struct packed {
        logic [IdW-1:0]   id;
        logic [AddrW-1:0] addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        logic             lock;
        logic [3:0]       cache;
        logic [2:0]       prot;
        logic [3:0]       qos;
        logic [UserW-1:0] user;
        nsaid_t           nsaid;
    } ax_nsaid_chan_t;

    typedef struct packed {
        logic [DataW-1:0] data;
        logic [StrbW-1:0] strb;
        logic             last;
        logic [UserW-1:0] user;
    } w_chan_t;

    typedef struct packed {
        logic [IdW-1:0]   id;
        logic [1:0]       resp;
        logic [UserW-1:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [IdW-1:0]   id;
        logic [DataW-1:0] data;
        logic [1:0]       resp;
        logic             last;
        logic [UserW-1:0] user;
    } r_chan_t;

    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        ax_nsaid_chan_t aw;
        logic           aw_valid;
        w_chan_t        w;
        logic           w_valid;
        logic           b_ready;
        ax_nsaid_chan_t ar;
        logic           ar_valid;
        logic           r_ready;
    } req_nsaid_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } resp_t;
endpackage

module axi_nsaid_tagger
    import axi_nsaid_tagger_pkg::*;
#(
    parameter int unsigned MaxTxns      = 8,
    parameter nsaid_t      DefaultNsaid = 4'h0,
    parameter int unsigned CntW         = $clog2(MaxTxns + 1)
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  req_t       slv_req_i,
    output resp_t      slv_resp_o,
    output req_nsaid_t mst_req_o,
    input  resp_t      mst_resp_i,
    input  logic [3:0] nsaid_cfg_i,
    input  logic       nsaid_cfg_valid_i,
    output logic       nsaid_cfg_ready_o,
    output logic [3:0] nsaid_o,
    output logic       busy_o
);

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_APPLY} state_e;

    state_e         r_state, w_state_nxt;
    nsaid_t         r_nsaid;
    logic           r_aw_full, r_ar_full;
    ax_nsaid_chan_t r_aw, r_ar;
    logic [CntW-1:0] r_wr_cnt, r_rd_cnt;

    logic w_cfg_pend, w_cfg_ready, w_drained;
    logic w_aw_admit, w_ar_admit, w_aw_ready, w_ar_ready;
    logic w_aw_load, w_ar_load, w_aw_fire, w_ar_fire, w_b_done, w_r_done;

    // Admission counts the held slot as already in flight, so cnt never exceeds MaxTxns.
    assign w_cfg_pend = (r_state != S_IDLE);
    assign w_aw_admit = ~w_cfg_pend & ((32'(r_wr_cnt) + 32'(r_aw_full)) < MaxTxns);
    assign w_ar_admit = ~w_cfg_pend & ((32'(r_rd_cnt) + 32'(r_ar_full)) < MaxTxns);
    assign w_aw_ready = w_aw_admit & (~r_aw_full | mst_resp_i.aw_ready);
    assign w_ar_ready = w_ar_admit & (~r_ar_full | mst_resp_i.ar_ready);
    assign w_aw_load  = slv_req_i.aw_valid & w_aw_ready;
    assign w_ar_load  = slv_req_i.ar_valid & w_ar_ready;
    assign w_aw_fire  = r_aw_full & mst_resp_i.aw_ready;
    assign w_ar_fire  = r_ar_full & mst_resp_i.ar_ready;
    assign w_b_done   = mst_resp_i.b_valid & slv_req_i.b_ready;
    assign w_r_done   = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;
    assign w_drained  = ~r_aw_full & ~r_ar_full & (r_wr_cnt == '0) & (r_rd_cnt == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_cfg_ready = 1'b0;
        case (r_state)
            S_IDLE:  if (nsaid_cfg_valid_i) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_drained) w_state_nxt = S_APPLY;
            S_APPLY: begin
                w_cfg_ready = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_nsaid   <= DefaultNsaid;
            r_aw_full <= 1'b0;
            r_ar_full <= 1'b0;
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_cfg_ready) r_nsaid <= nsaid_cfg_i;

            if (w_aw_load)      r_aw_full <= 1'b1;
            else if (w_aw_fire) r_aw_full <= 1'b0;
            if (w_ar_load)      r_ar_full <= 1'b1;
            else if (w_ar_fire) r_ar_full <= 1'b0;

            if (w_aw_fire & ~w_b_done)      r_wr_cnt <= r_wr_cnt + CntW'(1);
            else if (~w_aw_fire & w_b_done) r_wr_cnt <= r_wr_cnt - CntW'(1);
            if (w_ar_fire & ~w_r_done)      r_rd_cnt <= r_rd_cnt + CntW'(1);
            else if (~w_ar_fire & w_r_done) r_rd_cnt <= r_rd_cnt - CntW'(1);
        end
    end

    // The tag is captured with the beat, so a later NSAID change never retags a held request.
    always_ff @(posedge clk_i) begin
        if (w_aw_load) r_aw <= {slv_req_i.aw, r_nsaid};
        if (w_ar_load) r_ar <= {slv_req_i.ar, r_nsaid};
    end

    always_comb begin
        mst_req_o.aw       = r_aw;
        mst_req_o.aw_valid = r_aw_full;
        mst_req_o.w        = slv_req_i.w;
        mst_req_o.w_valid  = slv_req_i.w_valid;
        mst_req_o.b_ready  = slv_req_i.b_ready;
        mst_req_o.ar       = r_ar;
        mst_req_o.ar_valid = r_ar_full;
        mst_req_o.r_ready  = slv_req_i.r_ready;
    end

    always_comb begin
        slv_resp_o.aw_ready = w_aw_ready;
        slv_resp_o.ar_ready = w_ar_ready;
        slv_resp_o.w_ready  = mst_resp_i.w_ready;
        slv_resp_o.b_valid  = mst_resp_i.b_valid;
        slv_resp_o.b        = mst_resp_i.b;
        slv_resp_o.r_valid  = mst_resp_i.r_valid;
        slv_resp_o.r        = mst_resp_i.r;
    end

    assign nsaid_cfg_ready_o = w_cfg_ready;
    assign nsaid_o           = r_nsaid;
    assign busy_o            = r_aw_full | r_ar_full | (r_wr_cnt != '0) | (r_rd_cnt != '0);

endmodule
